// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings and constants shared by the ALU files
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_SHL  = 4'h4,
    OP_SHR  = 4'h5,
    OP_ROL  = 4'h6,
    OP_ROR  = 4'h7,
    OP_AND  = 4'h8,
    OP_OR   = 4'h9,
    OP_XOR  = 4'hA,
    OP_NOR  = 4'hB,
    OP_NAND = 4'hC,
    OP_XNOR = 4'hD,
    OP_GT   = 4'hE,
    OP_EQ   = 4'hF
  } opcode_e;

  localparam logic [7:0] DIV0_RESULT = 8'hFF;

endpackage

// File: rtl/alu_comb_core.sv
// rtl/alu_comb_core.sv - combinational next-result and next-carry for every opcode
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  opcode_e          op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;

  // One extra bit on sum/diff holds the carry-out and the borrow respectively.
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};
  assign prod = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    case (op_i)
      OP_ADD: {carry_o, result_o} = sum;
      OP_SUB: {carry_o, result_o} = diff;
      OP_MUL: begin
        result_o = prod[WIDTH-1:0];
        carry_o  = |prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        if (b_i == '0) begin
          result_o = WIDTH'(DIV0_RESULT);
          carry_o  = 1'b1;
        end else begin
          result_o = a_i / b_i;
        end
      end
      OP_SHL: {carry_o, result_o} = {a_i, 1'b0};
      OP_SHR: {result_o, carry_o} = {1'b0, a_i};
      OP_ROL: begin
        result_o = {a_i[WIDTH-2:0], a_i[WIDTH-1]};
        carry_o  = a_i[WIDTH-1];
      end
      OP_ROR: begin
        result_o = {a_i[0], a_i[WIDTH-1:1]};
        carry_o  = a_i[0];
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NOR:  result_o = ~(a_i | b_i);
      OP_NAND: result_o = ~(a_i & b_i);
      OP_XNOR: result_o = ~(a_i ^ b_i);
      OP_GT:   result_o = WIDTH'(a_i > b_i);
      OP_EQ:   result_o = WIDTH'(a_i == b_i);
      default: begin
        result_o = '0;
        carry_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/arithmetic_logic_unit.sv
// rtl/arithmetic_logic_unit.sv - registered 8-bit ALU: combinational core plus output flops
module arithmetic_logic_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic [3:0]       operation_select,
  output logic [WIDTH-1:0] result_output,
  output logic             carry_flag
);

  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d, carry_q;

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (input_a),
    .b_i      (input_b),
    .op_i     (opcode_e'(operation_select)),
    .result_o (result_d),
    .carry_o  (carry_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign result_output = result_q;
  assign carry_flag    = carry_q;

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// tb/tb_arithmetic_logic_unit.sv - scoreboard bench with directed ALU vectors
module tb_arithmetic_logic_unit;

  typedef struct {
    logic [7:0] res;
    logic       c;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] input_a;
  logic [7:0] input_b;
  logic [3:0] operation_select;
  logic [7:0] result_output;
  logic       carry_flag;

  exp_t       sb_q[$];
  int         errors;
  int         checks;
  logic [7:0] prev_res;
  logic       prev_c;

  arithmetic_logic_unit #(.WIDTH(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .input_a          (input_a),
    .input_b          (input_b),
    .operation_select (operation_select),
    .result_output    (result_output),
    .carry_flag       (carry_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] r, input logic c,
                       input logic [7:0] er, input logic ec);
    checks++;
    if (r !== er || c !== ec) begin
      errors++;
      $display("FAIL %s: got result=%h carry=%b, expected result=%h carry=%b",
               nm, r, c, er, ec);
    end
  endtask

  // Drive a vector after the falling edge; before the next rising edge the
  // outputs must still show the previous vector's result.
  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                       input logic [7:0] er, input logic ec, input string nm);
    exp_t e;
    @(negedge clk);
    input_a          = a;
    input_b          = b;
    operation_select = op;
    #1;
    check({nm, "_hold"}, result_output, carry_flag, prev_res, prev_c);
    e.res  = er;
    e.c    = ec;
    e.name = nm;
    sb_q.push_back(e);
    prev_res = er;
    prev_c   = ec;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.name, result_output, carry_flag, e.res, e.c);
      end
    end
  end

  initial begin
    errors   = 0;
    checks   = 0;
    prev_res = 8'h00;
    prev_c   = 1'b0;
    rst_n    = 1'b1;
    input_a  = 8'h00;
    input_b  = 8'h00;
    operation_select = 4'h0;
    #2 rst_n = 1'b0;
    #1 check("reset_initial", result_output, carry_flag, 8'h00, 1'b0);
    @(posedge clk);
    #1 check("reset_hold_initial", result_output, carry_flag, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    apply(8'h0F, 8'hF0, 4'h0, 8'hFF, 1'b0, "add");
    apply(8'h0F, 8'hF0, 4'h1, 8'h1F, 1'b1, "sub_borrow");
    apply(8'hFF, 8'h01, 4'h0, 8'h00, 1'b1, "add_overflow");
    apply(8'h00, 8'h01, 4'h1, 8'hFF, 1'b1, "sub_underflow");
    apply(8'h03, 8'h04, 4'h2, 8'h0C, 1'b0, "mul");
    apply(8'h10, 8'h10, 4'h2, 8'h00, 1'b1, "mul_high");
    apply(8'hFF, 8'hFF, 4'h2, 8'h01, 1'b1, "mul_ff");
    apply(8'h0C, 8'h04, 4'h3, 8'h03, 1'b0, "div");
    apply(8'h37, 8'h00, 4'h3, 8'hFF, 1'b1, "div_zero");
    apply(8'hAA, 8'h5A, 4'h4, 8'h54, 1'b1, "shl");
    apply(8'hAA, 8'h5A, 4'h5, 8'h55, 1'b0, "shr");
    apply(8'hAA, 8'h5A, 4'h6, 8'h55, 1'b1, "rol");
    apply(8'hAA, 8'h5A, 4'h7, 8'h55, 1'b0, "ror");
    apply(8'hFF, 8'h0F, 4'h8, 8'h0F, 1'b0, "and");
    apply(8'hFF, 8'h0F, 4'h9, 8'hFF, 1'b0, "or");
    apply(8'hFF, 8'h0F, 4'hA, 8'hF0, 1'b0, "xor");
    apply(8'hFF, 8'h0F, 4'hB, 8'h00, 1'b0, "nor");
    apply(8'hFF, 8'h0F, 4'hC, 8'hF0, 1'b0, "nand");
    apply(8'hFF, 8'h0F, 4'hD, 8'h0F, 1'b0, "xnor");
    apply(8'hAA, 8'hAA, 4'hF, 8'h01, 1'b0, "eq_true");
    apply(8'hAA, 8'hAA, 4'hE, 8'h00, 1'b0, "gt_false");
    apply(8'hAB, 8'hAA, 4'hE, 8'h01, 1'b0, "gt_true");
    apply(8'hAB, 8'hAA, 4'hF, 8'h00, 1'b0, "eq_false");
    apply(8'h81, 8'h00, 4'h1, 8'h81, 1'b0, "sub_nonzero");

    // Mid-cycle asynchronous reset after a non-zero result.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("reset_async", result_output, carry_flag, 8'h00, 1'b0);
    @(posedge clk);
    #1 check("reset_hold", result_output, carry_flag, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    // The first edge after release recomputes the still-applied SUB vector,
    // which the hold check inside the next apply observes.
    apply(8'hFF, 8'h01, 4'h0, 8'h00, 1'b1, "post_reset_add");
    apply(8'h0F, 8'hF0, 4'h0, 8'hFF, 1'b0, "post_reset_add2");

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
